// File: rtl/cmd_initiator.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------+
// | cmd_initiator: sends WR_REG/RD_REG packets on an AXI4-stream and |
// | checks the echoed response.                    Revision: 1.0     |
// +-----------------------------------------------------------------+
module cmd_initiator #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        cmd_wr,
   input  logic [7:0]  reg_num,
   input  logic [31:0] wr_data,
   output logic [31:0] tx_data,
   output logic [0:3]  tx_tkeep,
   output logic        tx_tvalid,
   output logic        tx_tlast,
   input  logic        tx_tready,
   input  logic [31:0] rx_data,
   input  logic [0:3]  rx_tkeep,
   input  logic        rx_tvalid,
   input  logic        rx_tlast,
   output logic        rx_tready,
   output logic        busy,
   output logic        done,
   output logic [31:0] rd_data,
   output logic [1:0]  err
);

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      TX_CSN  = 4'd1,
      TX_CC   = 4'd2,
      TX_REG  = 4'd3,
      TX_DATA = 4'd4,
      RX_CSN  = 4'd5,
      RX_CC   = 4'd6,
      RX_REG  = 4'd7,
      RX_DATA = 4'd8,
      DRAIN   = 4'd9,
      FINISH  = 4'd10
   } state_t;

   localparam int                 c_tmo_w    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0]        c_cc_wr    = 32'h0000_0003;
   localparam logic [31:0]        c_cc_rd    = 32'h0000_0002;
   localparam logic [27:0]        c_seq_max  = 28'hFFF_FFFF;

   state_t             state_q, state_d;
   logic               cmd_wr_q, cmd_wr_d;
   logic [7:0]         reg_num_q, reg_num_d;
   logic [31:0]        wr_data_q, wr_data_d;
   logic [27:0]        seq_q, seq_d;
   logic [31:0]        rd_data_q, rd_data_d;
   logic [1:0]         err_q, err_d;
   logic [c_tmo_w-1:0] tmo_q, tmo_d;

   logic [31:0] csn_word, cc_word, reg_word, exp_word;
   logic        tx_hs, rx_hs, in_rx, unused_tkeep;

   assign csn_word = {4'h1, seq_q};
   assign cc_word  = cmd_wr_q ? c_cc_wr : c_cc_rd;
   assign reg_word = {24'h0, reg_num_q};

   assign in_rx     = state_q inside {RX_CSN, RX_CC, RX_REG, RX_DATA, DRAIN};
   assign tx_tvalid = state_q inside {TX_CSN, TX_CC, TX_REG, TX_DATA};
   assign tx_tlast  = (state_q == TX_DATA) || ((state_q == TX_REG) && !cmd_wr_q);
   assign tx_tkeep  = 4'b1111;
   assign rx_tready = in_rx;
   assign busy      = !(state_q inside {IDLE, FINISH});
   assign done      = (state_q == FINISH);
   assign rd_data   = rd_data_q;
   assign err       = err_q;

   assign tx_hs        = tx_tvalid && tx_tready;
   assign rx_hs        = rx_tvalid && rx_tready;
   assign unused_tkeep = ^rx_tkeep;

   // Outgoing word and the echo expected back share the latched command fields.
   always_comb begin
      tx_data  = '0;
      exp_word = '0;
      case (state_q)
         TX_CSN:  tx_data = csn_word;
         TX_CC:   tx_data = cc_word;
         TX_REG:  tx_data = reg_word;
         TX_DATA: tx_data = wr_data_q;
         RX_CSN:  exp_word = csn_word;
         RX_CC:   exp_word = cc_word;
         RX_REG:  exp_word = reg_word;
         default: ;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cmd_wr_d  = cmd_wr_q;
      reg_num_d = reg_num_q;
      wr_data_d = wr_data_q;
      seq_d     = seq_q;
      rd_data_d = rd_data_q;
      err_d     = err_q;
      tmo_d     = tmo_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               cmd_wr_d  = cmd_wr;
               reg_num_d = reg_num;
               wr_data_d = wr_data;
               state_d   = TX_CSN;
            end
         end
         TX_CSN: if (tx_hs) state_d = TX_CC;
         TX_CC:  if (tx_hs) state_d = TX_REG;
         TX_REG: begin
            if (tx_hs) begin
               state_d = cmd_wr_q ? TX_DATA : RX_CSN;
               tmo_d   = '0;
            end
         end
         TX_DATA: begin
            if (tx_hs) begin
               state_d = RX_CSN;
               tmo_d   = '0;
            end
         end
         RX_CSN, RX_CC, RX_REG: begin
            // An echo mismatch takes priority over a premature tlast.
            if (rx_hs) begin
               if (rx_data != exp_word) begin
                  err_d   = 2'd1;
                  state_d = rx_tlast ? FINISH : DRAIN;
               end else if (rx_tlast) begin
                  err_d   = 2'd2;
                  state_d = FINISH;
               end else begin
                  state_d = (state_q == RX_CSN) ? RX_CC :
                            (state_q == RX_CC)  ? RX_REG : RX_DATA;
               end
            end
         end
         RX_DATA: begin
            if (rx_hs) begin
               if (rx_tlast) begin
                  rd_data_d = rx_data;
                  err_d     = 2'd0;
                  state_d   = FINISH;
               end else begin
                  err_d   = 2'd2;
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: if (rx_hs && rx_tlast) state_d = FINISH;
         FINISH: begin
            seq_d   = (seq_q == c_seq_max) ? 28'd1 : seq_q + 28'd1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A handshake in the expiry cycle restarts the wait instead of aborting.
      if (in_rx) begin
         if (rx_hs) begin
            tmo_d = '0;
         end else if (tmo_q == c_tmo_last) begin
            err_d   = 2'd3;
            state_d = FINISH;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cmd_wr_q  <= 1'b0;
         reg_num_q <= '0;
         wr_data_q <= '0;
         seq_q     <= 28'd1;
         rd_data_q <= '0;
         err_q     <= '0;
         tmo_q     <= '0;
      end else begin
         state_q   <= state_d;
         cmd_wr_q  <= cmd_wr_d;
         reg_num_q <= reg_num_d;
         wr_data_q <= wr_data_d;
         seq_q     <= seq_d;
         rd_data_q <= rd_data_d;
         err_q     <= err_d;
         tmo_q     <= tmo_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cmd_initiator.sv
`timescale 1ns/1ps
`default_nettype none
// tb_cmd_initiator: randomized command/response traffic checked against a
// scoreboard fed by a packet-level model of the initiator.
module tb_cmd_initiator;

   localparam int TMO = 16;
   localparam int K_OK = 0, K_MIS = 1, K_MIS_LAST = 2, K_EARLY = 3, K_NOLAST = 4, K_TMO = 5;

   logic        clk = 1'b0;
   logic        reset, start, cmd_wr;
   logic [7:0]  reg_num;
   logic [31:0] wr_data, tx_data, rx_data, rd_data;
   logic [0:3]  tx_tkeep, rx_tkeep;
   logic        tx_tvalid, tx_tlast, tx_tready;
   logic        rx_tvalid, rx_tlast, rx_tready;
   logic        busy, done;
   logic [1:0]  err;

   cmd_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset), .start(start), .cmd_wr(cmd_wr), .reg_num(reg_num),
      .wr_data(wr_data), .tx_data(tx_data), .tx_tkeep(tx_tkeep), .tx_tvalid(tx_tvalid),
      .tx_tlast(tx_tlast), .tx_tready(tx_tready), .rx_data(rx_data), .rx_tkeep(rx_tkeep),
      .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast), .rx_tready(rx_tready), .busy(busy),
      .done(done), .rd_data(rd_data), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {logic [31:0] data; logic last;} tx_exp_t;
   typedef struct {logic [1:0] err; logic [31:0] rd;} res_t;

   tx_exp_t sb_tx[$];
   res_t    sb_res[$];

   int n_checks = 0, n_fail = 0;
   int cyc = 0, last_hs_cyc = 0, done_cyc = 0, tx_hs_cnt = 0, tx_pkts = 0, done_cnt = 0;
   int rdy_mode = 1;   // 0 random, 1 always ready, 2 never ready, 3 toggling
   logic [27:0] model_seq;
   logic [31:0] model_rd;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic        prev_stall;
      logic [31:0] prev_data;
      logic        prev_last;
      tx_exp_t     e;
      res_t        r;
      prev_stall = 1'b0;
      prev_data  = '0;
      prev_last  = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("tx_hold_valid", 32'(tx_tvalid), 32'd1);
               check("tx_hold_data", tx_data, prev_data);
               check("tx_hold_last", 32'(tx_tlast), 32'(prev_last));
            end
            if (tx_tvalid) check("tx_tkeep", 32'(tx_tkeep), 32'hF);
            if (tx_tvalid && tx_tready) begin
               tx_hs_cnt++;
               last_hs_cyc = cyc;
               if (sb_tx.size() == 0) begin
                  check("tx_unexpected_word", tx_data, 32'hxxxx_xxxx);
               end else begin
                  e = sb_tx.pop_front();
                  check("tx_word", tx_data, e.data);
                  check("tx_word_tlast", 32'(tx_tlast), 32'(e.last));
               end
               if (tx_tlast) tx_pkts++;
            end
            prev_stall = tx_tvalid && !tx_tready;
            prev_data  = tx_data;
            prev_last  = tx_tlast;
            if (rx_tvalid && rx_tready) last_hs_cyc = cyc;
            if (done) begin
               done_cnt++;
               done_cyc = cyc;
               check("busy_at_done", 32'(busy), 32'd0);
               if (sb_res.size() == 0) begin
                  check("unexpected_done", 32'(done), 32'd0);
               end else begin
                  r = sb_res.pop_front();
                  check("done_err", 32'(err), 32'(r.err));
                  check("done_rd_data", rd_data, r.rd);
               end
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic tick();
      @(posedge clk);
      #2;
      case (rdy_mode)
         0:       tx_tready = 1'($urandom);
         1:       tx_tready = 1'b1;
         2:       tx_tready = 1'b0;
         default: tx_tready = ~tx_tready;
      endcase
   endtask

   task automatic issue(input logic wr, input logic [7:0] rn, input logic [31:0] wd);
      tx_exp_t e;
      e.data = {4'h1, model_seq}; e.last = 1'b0; sb_tx.push_back(e);
      e.data = wr ? 32'h3 : 32'h2;                 sb_tx.push_back(e);
      e.data = {24'h0, rn};       e.last = !wr;    sb_tx.push_back(e);
      if (wr) begin
         e.data = wd; e.last = 1'b1; sb_tx.push_back(e);
      end
      start = 1'b1; cmd_wr = wr; reg_num = rn; wr_data = wd;
      tick();
      start = 1'b0; cmd_wr = 1'($urandom); reg_num = 8'($urandom); wr_data = $urandom;
   endtask

   task automatic run_cmd(input logic wr, input logic [7:0] rn, input logic [31:0] wd,
                          input int kind, input int w, input logic [31:0] rdval,
                          input logic [31:0] bad);
      logic [31:0] good [4];
      logic [31:0] rw[$];
      logic        rl[$];
      res_t        r;
      int          pk0, d0, guard, gap;
      good[0] = {4'h1, model_seq};
      good[1] = wr ? 32'h3 : 32'h2;
      good[2] = {24'h0, rn};
      good[3] = wr ? wd : rdval;
      case (kind)
         K_OK: begin
            for (int i = 0; i < 4; i++) begin rw.push_back(good[i]); rl.push_back(i == 3); end
            r.err = 2'd0;
         end
         K_MIS: begin
            for (int i = 0; i < 4; i++) begin rw.push_back(good[i]); rl.push_back(i == 3); end
            rw[w] = rw[w] ^ bad;
            r.err = 2'd1;
         end
         K_MIS_LAST: begin
            for (int i = 0; i <= w; i++) begin rw.push_back(good[i]); rl.push_back(i == w); end
            rw[w] = rw[w] ^ bad;
            r.err = 2'd1;
         end
         K_EARLY: begin
            for (int i = 0; i <= w; i++) begin rw.push_back(good[i]); rl.push_back(i == w); end
            r.err = 2'd2;
         end
         K_NOLAST: begin
            for (int i = 0; i < 4; i++) begin rw.push_back(good[i]); rl.push_back(1'b0); end
            for (int j = 0; j < w; j++) begin rw.push_back($urandom); rl.push_back(j == w - 1); end
            r.err = 2'd2;
         end
         default: begin
            for (int i = 0; i < w; i++) begin rw.push_back(good[i]); rl.push_back(1'b0); end
            r.err = 2'd3;
         end
      endcase
      r.rd = (r.err == 2'd0) ? good[3] : model_rd;
      sb_res.push_back(r);

      repeat ($urandom_range(0, 2)) tick();
      pk0 = tx_pkts;
      d0  = done_cnt;
      issue(wr, rn, wd);
      guard = 0;
      while (tx_pkts == pk0 && guard < 200) begin
         start = 1'($urandom); tick(); guard++;
      end
      start = 1'b0;
      check("tx_packet_complete", 32'(tx_pkts - pk0), 32'd1);

      for (int i = 0; i < rw.size(); i++) begin
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            rx_tvalid = 1'b0; start = 1'($urandom); tick();
         end
         rx_tvalid = 1'b1; rx_data = rw[i]; rx_tlast = rl[i]; rx_tkeep = 4'($urandom);
         guard = 0;
         while (!rx_tready && guard < 50) begin tick(); guard++; end
         tick();
      end
      rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_data = $urandom;

      guard = 0;
      while (done_cnt == d0 && guard < 100) begin
         start = 1'($urandom); tick(); guard++;
      end
      start = 1'b0;
      check("done_seen", 32'(done_cnt - d0), 32'd1);
      check("done_latency", 32'(done_cyc - last_hs_cyc), (kind == K_TMO) ? 32'd17 : 32'd1);
      check("err_held", 32'(err), 32'(r.err));
      if (r.err == 2'd0) model_rd = good[3];
      model_seq = (model_seq == 28'hFFF_FFFF) ? 28'd1 : model_seq + 28'd1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tx_tvalid"}, 32'(tx_tvalid), 32'd0);
      check({tag, "_tx_tlast"},  32'(tx_tlast),  32'd0);
      check({tag, "_tx_data"},   tx_data,        32'd0);
      check({tag, "_rx_tready"}, 32'(rx_tready), 32'd0);
      check({tag, "_busy"},      32'(busy),      32'd0);
      check({tag, "_done"},      32'(done),      32'd0);
      check({tag, "_err"},       32'(err),       32'd0);
      check({tag, "_rd_data"},   rd_data,        32'd0);
   endtask

   task automatic reset_mid_packet();
      int base, guard;
      repeat (2) tick();
      rdy_mode = 1;
      base = tx_hs_cnt;
      issue(1'b1, 8'h5a, 32'hdead_beef);
      guard = 0;
      while (tx_hs_cnt < base + 2 && guard < 50) begin tick(); guard++; end
      rdy_mode  = 2;
      tx_tready = 1'b0;
      check("stall_tx_reg_valid", 32'(tx_tvalid), 32'd1);
      check("stall_tx_reg_data", tx_data, 32'h0000_005a);
      reset = 1'b1;
      tick();
      check_reset_outputs("mid_reset");
      reset = 1'b0;
      sb_tx.delete();
      sb_res.delete();
      model_seq = 28'd1;
      model_rd  = '0;
      rdy_mode  = 1;
   endtask

   initial begin
      int kind, w, m;
      reset = 1'b1; start = 1'b0; cmd_wr = 1'b0; reg_num = '0; wr_data = '0;
      tx_tready = 1'b0; rx_data = '0; rx_tkeep = 4'hF; rx_tvalid = 1'b0; rx_tlast = 1'b0;
      model_seq = 28'd1;
      model_rd  = '0;
      repeat (3) tick();
      check_reset_outputs("por");
      reset = 1'b0;
      tick();

      rdy_mode = 1;
      run_cmd(1'b1, 8'h0d, 32'h0000_0135, K_OK, 0, 32'h0, 32'h0);
      rdy_mode = 3;
      run_cmd(1'b0, 8'h0e, 32'hffff_ffff, K_OK, 0, 32'h2222_2222, 32'h0);
      check("rd_data_after_read", rd_data, 32'h2222_2222);
      rdy_mode = 1;
      run_cmd(1'b1, 8'h21, 32'h77, K_MIS, 0, 32'h0, 32'h1000_0099 ^ {4'h1, model_seq});
      check("rd_data_kept_on_error", rd_data, 32'h2222_2222);
      run_cmd(1'b0, 8'h10, 32'h0, K_TMO, 0, 32'h0, 32'h0);
      run_cmd(1'b0, 8'h11, 32'h0, K_OK, 0, 32'h0bad_cafe, 32'h0);
      run_cmd(1'b0, 8'h11, 32'h0, K_EARLY, 1, $urandom, 32'h0);
      run_cmd(1'b1, 8'h12, 32'h5555, K_NOLAST, 2, 32'h0, 32'h0);
      reset_mid_packet();
      run_cmd(1'b1, 8'h13, 32'h1234, K_OK, 0, 32'h0, 32'h0);

      for (int n = 0; n < 60; n++) begin
         m = $urandom_range(0, 2);
         rdy_mode = (m == 2) ? 3 : m;
         kind = $urandom_range(0, 5);
         case (kind)
            K_NOLAST: w = $urandom_range(1, 3);
            K_TMO:    w = $urandom_range(0, 3);
            K_OK:     w = 0;
            default:  w = $urandom_range(0, 2);
         endcase
         run_cmd(1'($urandom), 8'($urandom), $urandom, kind, w, $urandom, $urandom | 32'h1);
      end

      repeat (3) tick();
      check("sb_tx_empty", 32'(sb_tx.size()), 32'd0);
      check("sb_res_empty", 32'(sb_res.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got time %0t expected < 500000", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
